// File: rtl/gf_pkg.sv
// gf_pkg
// Shared definitions for the GF(2^m) arithmetic blocks.
//   GF_MMAX      default maximum field degree (operand/result width)
//   GF_OP_ADD    op encoding for field addition
//   GF_OP_MUL    op encoding for bit-serial field multiplication
//   gf_state_t   sequencing states of the serial ALU
package gf_pkg;

  localparam int GF_MMAX = 8;

  localparam logic GF_OP_ADD = 1'b0;
  localparam logic GF_OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gf_state_t;

endpackage

// File: rtl/gf_mulstep.sv
// gf_mulstep
// One combinational MSB-first shift-and-add multiplication step in GF(2^m).
// Ports:
//   acc        in   MMAX    running product
//   a          in   MMAX    multiplicand, added when b_bit is set
//   b_bit      in   1       current multiplier bit
//   prim_poly  in   MMAX+1  reduction polynomial, bit k = coefficient of x^k
//   m          in   MW      field degree (1..MMAX)
//   acc_next   out  MMAX    acc*x mod prim_poly, plus a if b_bit
module gf_mulstep
  import gf_pkg::*;
#(
  parameter int MMAX = GF_MMAX,
  parameter int MW   = $clog2(MMAX + 1)
) (
  input  logic [MMAX-1:0] acc,
  input  logic [MMAX-1:0] a,
  input  logic            b_bit,
  input  logic [MMAX:0]   prim_poly,
  input  logic [MW-1:0]   m,
  output logic [MMAX-1:0] acc_next
);

  logic [MMAX-1:0] mask;
  logic            msb;

  // The field width is a runtime value, so the degree-m mask and the bit
  // that overflows out of the field (acc[m-1]) are picked out by loop.
  // x^m folds back as prim_poly[m-1:0].
  always_comb begin
    mask = '0;
    msb  = 1'b0;
    for (int i = 0; i < MMAX; i++) begin
      if (i < int'(m)) mask[i] = 1'b1;
      if (i == int'(m) - 1) msb = acc[i];
    end
    acc_next = (acc << 1) & mask;
    if (msb) acc_next = acc_next ^ (prim_poly[MMAX-1:0] & mask);
    if (b_bit) acc_next = acc_next ^ a;
  end

endmodule

// File: rtl/gf_alu_serial.sv
// gf_alu_serial
// Runtime-configurable GF(2^m) ALU: single-cycle add, bit-serial multiply,
// valid/ready handshake on request and result sides, one op in flight.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   op                    GF_OP_ADD or GF_OP_MUL
//   m                     field degree for this request
//   prim_poly             reduction polynomial of degree m
//   a, b                  operands, must fit in m bits
//   out_valid / out_ready result handshake
//   result                field result (zero when err)
//   err                   request was illegal, qualified by out_valid
module gf_alu_serial
  import gf_pkg::*;
#(
  parameter int MMAX = GF_MMAX,
  parameter int MW   = $clog2(MMAX + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op,
  input  logic [MW-1:0]   m,
  input  logic [MMAX:0]   prim_poly,
  input  logic [MMAX-1:0] a,
  input  logic [MMAX-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MMAX-1:0] result,
  output logic            err
);

  gf_state_t       state;
  logic [MW-1:0]   m_q;
  logic [MW-1:0]   cnt;
  logic [MMAX:0]   poly_q;
  logic [MMAX-1:0] a_q;
  logic [MMAX-1:0] b_q;
  logic [MMAX-1:0] acc;
  logic [MMAX-1:0] acc_next;
  logic            legal;
  logic            top_set;
  logic            b_sel;

  // Request legality, evaluated on the request being accepted. The degree
  // term must be present, the constant term must be present, nothing above
  // x^m may be set, and both operands must already be reduced.
  always_comb begin
    legal   = (m != '0) && (int'(m) <= MMAX) && prim_poly[0];
    top_set = 1'b0;
    for (int i = 0; i <= MMAX; i++) begin
      if (i == int'(m)) top_set = prim_poly[i];
      if ((i > int'(m)) && prim_poly[i]) legal = 1'b0;
    end
    for (int i = 0; i < MMAX; i++) begin
      if ((i >= int'(m)) && (a[i] || b[i])) legal = 1'b0;
    end
    if (!top_set) legal = 1'b0;
  end

  // Multiplier bit for this CALC cycle; loop select keeps the index width
  // independent of the counter width.
  always_comb begin
    b_sel = 1'b0;
    for (int i = 0; i < MMAX; i++) begin
      if (i == int'(cnt)) b_sel = b_q[i];
    end
  end

  gf_mulstep #(
    .MMAX(MMAX),
    .MW  (MW)
  ) u_step (
    .acc      (acc),
    .a        (a_q),
    .b_bit    (b_sel),
    .prim_poly(poly_q),
    .m        (m_q),
    .acc_next (acc_next)
  );

  // Sequencer with registered handshake outputs. Add and illegal requests
  // go straight to DONE; multiply walks b from bit m-1 down to bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      m_q       <= '0;
      cnt       <= '0;
      poly_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_q      <= m;
            poly_q   <= prim_poly;
            a_q      <= a;
            b_q      <= b;
            in_ready <= 1'b0;
            if (!legal) begin
              result    <= '0;
              err       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (op == GF_OP_ADD) begin
              result    <= a ^ b;
              err       <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              acc   <= '0;
              cnt   <= m - 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          if (cnt == '0) begin
            result    <= acc_next;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_alu_serial.sv
// tb_gf_alu_serial
// Self-checking bench for gf_alu_serial: directed vector table, randomized
// requests against a polynomial-arithmetic reference model, plus
// backpressure and mid-operation reset sequences.
module tb_gf_alu_serial;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       op;
  logic [3:0] m;
  logic [8:0] prim_poly;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       err;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       op;
    logic [3:0] m;
    logic [8:0] poly;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  gf_alu_serial dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .m        (m),
    .prim_poly(prim_poly),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against the required value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Field arithmetic from first principles: carry-less product followed by
  // polynomial long division by prim_poly.
  function automatic void refModel(input int op_i, input int m_i, input int poly_i,
                                   input int a_i, input int b_i,
                                   output int res, output int e, output int lat);
    int prod;
    bit ok;
    ok = (m_i >= 1) && (m_i <= 8) && ((poly_i >> m_i) == 1) && ((poly_i % 2) == 1)
         && ((a_i >> m_i) == 0) && ((b_i >> m_i) == 0);
    if (!ok) begin
      res = 0; e = 1; lat = 1;
    end else if (op_i == 0) begin
      res = a_i ^ b_i; e = 0; lat = 1;
    end else begin
      prod = 0;
      for (int i = 0; i < 8; i++)
        if (((b_i >> i) & 1) == 1) prod = prod ^ (a_i << i);
      for (int d = 14; d >= m_i; d--)
        if (((prod >> d) & 1) == 1) prod = prod ^ (poly_i << (d - m_i));
      res = prod; e = 0; lat = m_i + 1;
    end
  endfunction

  // Issues one request from a negedge, measures latency to out_valid,
  // returns the result and consumes it. Ends on a negedge.
  task automatic applyStimulus(input logic op_i, input logic [3:0] m_i, input logic [8:0] poly_i,
                               input logic [7:0] a_i, input logic [7:0] b_i,
                               output logic [7:0] res_o, output logic err_o, output int lat_o);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    in_valid  = 1'b1;
    op        = op_i;
    m         = m_i;
    prim_poly = poly_i;
    a         = a_i;
    b         = b_i;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat_o = 1;
    while (!out_valid && lat_o < 40) begin
      @(negedge clk);
      lat_o++;
    end
    if (!out_valid) checkOutput("valid_timeout", 32'd0, 32'd1);
    res_o = result;
    err_o = err;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    logic [7:0] r;
    logic       e;
    int         lat;
    int         em, ee, el;
    int         mi, pi, ai, bi, oi;
    int         sticky;

    checks = 0;
    errors = 0;

    vecs[0]  = '{"mul3_2x3",    1'b1, 4'd3, 9'b000001011, 8'h02, 8'h03, 8'h06, 1'b0, 4};
    vecs[1]  = '{"mul3_7x4",    1'b1, 4'd3, 9'b000001011, 8'h07, 8'h04, 8'h01, 1'b0, 4};
    vecs[2]  = '{"add4",        1'b0, 4'd4, 9'b000010011, 8'h0A, 8'h06, 8'h0C, 1'b0, 1};
    vecs[3]  = '{"mul4",        1'b1, 4'd4, 9'b000010011, 8'h0A, 8'h06, 8'h09, 1'b0, 5};
    vecs[4]  = '{"err_nodeg",   1'b0, 4'd2, 9'b000010000, 8'h01, 8'h02, 8'h00, 1'b1, 1};
    vecs[5]  = '{"err_abit",    1'b1, 4'd3, 9'b000001011, 8'h08, 8'h01, 8'h00, 1'b1, 1};
    vecs[6]  = '{"err_m0",      1'b0, 4'd0, 9'b000001011, 8'h00, 8'h00, 8'h00, 1'b1, 1};
    vecs[7]  = '{"err_m9",      1'b1, 4'd9, 9'h11B,       8'h01, 8'h01, 8'h00, 1'b1, 1};
    vecs[8]  = '{"err_noconst", 1'b1, 4'd3, 9'b000001010, 8'h01, 8'h01, 8'h00, 1'b1, 1};
    vecs[9]  = '{"err_highbit", 1'b1, 4'd3, 9'b000011011, 8'h01, 8'h01, 8'h00, 1'b1, 1};
    vecs[10] = '{"mul8_aes",    1'b1, 4'd8, 9'h11B,       8'h53, 8'hCA, 8'h01, 1'b0, 9};
    vecs[11] = '{"mul1",        1'b1, 4'd1, 9'b000000011, 8'h01, 8'h01, 8'h01, 1'b0, 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 1'b0;
    m         = '0;
    prim_poly = '0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].m, vecs[i].poly, vecs[i].a, vecs[i].b, r, e, lat);
      checkOutput({vecs[i].name, "_result"}, r, vecs[i].res);
      checkOutput({vecs[i].name, "_err"}, e, vecs[i].err);
      checkOutput({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      checkOutput({vecs[i].name, "_consumed"}, out_valid, 0);
      checkOutput({vecs[i].name, "_ready_back"}, in_ready, 1);
    end

    // Randomized requests, mostly legal, some deliberately broken
    for (int n = 0; n < 200; n++) begin
      oi = $urandom_range(0, 1);
      mi = $urandom_range(1, 8);
      pi = (1 << mi) | 1 | ($urandom & ((1 << mi) - 1));
      ai = $urandom & ((1 << mi) - 1);
      bi = $urandom & ((1 << mi) - 1);
      case ($urandom_range(0, 11))
        0: mi = 0;
        1: if (mi < 8) ai = ai | (1 << $urandom_range(mi, 7));
        2: pi = pi & ~1;
        3: if (mi < 8) pi = pi | (1 << $urandom_range(mi + 1, 8));
        default: ;
      endcase
      refModel(oi, mi, pi, ai, bi, em, ee, el);
      applyStimulus(oi[0], mi[3:0], pi[8:0], ai[7:0], bi[7:0], r, e, lat);
      checkOutput("rand_result", r, em);
      checkOutput("rand_err", e, ee);
      checkOutput("rand_latency", lat, el);
    end

    // Backpressure: result held through 3 stalled cycles with in_valid high
    in_valid  = 1'b1;
    op        = 1'b0;
    m         = 4'd4;
    prim_poly = 9'b000010011;
    a         = 8'h03;
    b         = 8'h05;
    @(posedge clk);
    @(negedge clk);
    a = 8'h09;
    b = 8'h01;
    checkOutput("bp_valid", out_valid, 1);
    checkOutput("bp_result", result, 8'h06);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_result", result, 8'h06);
      checkOutput("bp_hold_err", err, 0);
      checkOutput("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_next_accepted", in_ready, 0);
    checkOutput("bp_next_valid", out_valid, 1);
    checkOutput("bp_next_result", result, 8'h08);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of an m=4 multiply
    in_valid  = 1'b1;
    op        = 1'b1;
    m         = 4'd4;
    prim_poly = 9'b000010011;
    a         = 8'h0A;
    b         = 8'h06;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_in_ready", in_ready, 1);
    checkOutput("mrst_out_valid", out_valid, 0);
    checkOutput("mrst_result", result, 0);
    checkOutput("mrst_err", err, 0);
    sticky = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) sticky = 1;
    end
    checkOutput("mrst_no_valid", sticky, 0);
    applyStimulus(1'b0, 4'd4, 9'b000010011, 8'h0A, 8'h06, r, e, lat);
    checkOutput("post_rst_result", r, 8'h0C);
    checkOutput("post_rst_err", e, 0);
    checkOutput("post_rst_latency", lat, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
